// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Shared constants for the control sequencer. Holds the
//                sequencer state encoding, the NOP opcode value, and the
//                default block-address and opcode widths that the control
//                memory and compute array also use.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    // Widths shared with the control memory and the compute array
    localparam int c_ADDR_BITS  = 6;
    localparam int c_OP_BITS    = 4;

    // Opcode zero retires without touching memory or the compute array
    localparam int c_OP_NOP     = 0;

    // Sequencer state encoding
    localparam int         c_STATE_BITS = 3;
    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_READ    = 3'd1;
    localparam logic [2:0] c_ST_START   = 3'd2;
    localparam logic [2:0] c_ST_WAIT    = 3'd3;
    localparam logic [2:0] c_ST_WRITE   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/ctrl_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_timeout
//  Description : Watchdog counter for the compute-array wait. Cleared to
//                zero by clr, counts up one step per cycle while en is high,
//                and flags expired during the cycle in which the count of
//                enabled cycles reaches TIMEOUT_CYCLES.
//  Ports       : clk, rst      - clock, asynchronous active-high reset
//                clr           - load the counter with zero
//                en            - count this cycle
//                expired       - this enabled cycle is the last allowed one
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_timeout #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int c_CNT_BITS = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_BITS-1:0] c_LAST = c_CNT_BITS'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_BITS-1:0] r_count;
    logic                  w_at_last;

    // r_count holds the number of enabled cycles already elapsed, so the
    // current enabled cycle is number r_count+1.
    assign w_at_last = (r_count == c_LAST);
    assign expired   = en && w_at_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && !w_at_last) begin
            // Saturate so a stalled enable never wraps back to a short count
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ctrl_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_sequencer
//  Description : Runs one compute-graph operation at a time: accepts an
//                instruction, reads both operand blocks from the control
//                memory, starts the compute array, and writes the result
//                block back. Owns all memory address and write-enable lines.
//  Ports       : instr_valid/instr_ready       - instruction handshake
//                instr_op/_a/_b/_dst           - opcode and block addresses
//                mem_addr_a/_b, mem_addr_i     - memory read/write addresses
//                mem_write                     - memory write enable
//                cu_start, cu_op, cu_done      - compute array control
//                busy, err_timeout, err_clear  - status and sticky error
//                op_count                      - retired instruction count
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int ADDR_BITS      = c_ADDR_BITS,
    parameter int OP_BITS        = c_OP_BITS,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [OP_BITS-1:0]   instr_op,
    input  logic [ADDR_BITS-1:0] instr_a,
    input  logic [ADDR_BITS-1:0] instr_b,
    input  logic [ADDR_BITS-1:0] instr_dst,
    output logic [ADDR_BITS-1:0] mem_addr_a,
    output logic [ADDR_BITS-1:0] mem_addr_b,
    output logic [ADDR_BITS-1:0] mem_addr_i,
    output logic                 mem_write,
    output logic                 cu_start,
    output logic [OP_BITS-1:0]   cu_op,
    input  logic                 cu_done,
    output logic                 busy,
    output logic                 err_timeout,
    input  logic                 err_clear,
    output logic [15:0]          op_count
);

    logic [c_STATE_BITS-1:0] r_state;
    logic [OP_BITS-1:0]      r_op;
    logic [ADDR_BITS-1:0]    r_dst;

    logic w_accept;
    logic w_is_nop;
    logic w_tmo_clr;
    logic w_tmo_en;
    logic w_expired;

    assign w_accept  = instr_valid && instr_ready;
    assign w_is_nop  = (instr_op == OP_BITS'(c_OP_NOP));
    assign w_tmo_clr = (r_state == c_ST_START);
    assign w_tmo_en  = (r_state == c_ST_WAIT);

    ctrl_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_tmo_clr),
        .en      (w_tmo_en),
        .expired (w_expired)
    );

    // Every output is a flop; each is updated on the transition into the
    // state in which it must be visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_op        <= '0;
            r_dst       <= '0;
            instr_ready <= 1'b1;
            mem_addr_a  <= '0;
            mem_addr_b  <= '0;
            mem_addr_i  <= '0;
            mem_write   <= 1'b0;
            cu_start    <= 1'b0;
            cu_op       <= '0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            op_count    <= '0;
        end else begin
            // Clear first so a timeout set later in this block overrides it
            if (err_clear) begin
                err_timeout <= 1'b0;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_op  <= instr_op;
                        r_dst <= instr_dst;
                        if (w_is_nop) begin
                            op_count <= op_count + 16'd1;
                        end else begin
                            mem_addr_a  <= instr_a;
                            mem_addr_b  <= instr_b;
                            instr_ready <= 1'b0;
                            busy        <= 1'b1;
                            r_state     <= c_ST_READ;
                        end
                    end
                end

                // Memory captures the operands at the end of this cycle
                c_ST_READ: begin
                    cu_start <= 1'b1;
                    cu_op    <= r_op;
                    r_state  <= c_ST_START;
                end

                c_ST_START: begin
                    cu_start <= 1'b0;
                    r_state  <= c_ST_WAIT;
                end

                // A done on the final allowed cycle still counts as success
                c_ST_WAIT: begin
                    if (cu_done) begin
                        mem_addr_i <= r_dst;
                        mem_write  <= 1'b1;
                        r_state    <= c_ST_WRITE;
                    end else if (w_expired) begin
                        err_timeout <= 1'b1;
                        op_count    <= op_count + 16'd1;
                        instr_ready <= 1'b1;
                        busy        <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end
                end

                c_ST_WRITE: begin
                    mem_write   <= 1'b0;
                    op_count    <= op_count + 16'd1;
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                    r_state     <= c_ST_IDLE;
                end

                default: begin
                    cu_start    <= 1'b0;
                    mem_write   <= 1'b0;
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                    r_state     <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctrl_sequencer
//  Description : Scoreboard bench for ctrl_sequencer. The driver derives the
//                expected start, write and retire events (with their cycle
//                numbers) from the instruction timing rules and queues them;
//                a monitor pops and compares whenever the DUT presents one.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_sequencer;

    localparam int c_AW = 6;
    localparam int c_OW = 4;
    localparam int c_TO = 8;

    logic            clk;
    logic            rst;
    logic            instr_valid;
    logic            instr_ready;
    logic [c_OW-1:0] instr_op;
    logic [c_AW-1:0] instr_a;
    logic [c_AW-1:0] instr_b;
    logic [c_AW-1:0] instr_dst;
    logic [c_AW-1:0] mem_addr_a;
    logic [c_AW-1:0] mem_addr_b;
    logic [c_AW-1:0] mem_addr_i;
    logic            mem_write;
    logic            cu_start;
    logic [c_OW-1:0] cu_op;
    logic            cu_done;
    logic            busy;
    logic            err_timeout;
    logic            err_clear;
    logic [15:0]     op_count;

    ctrl_sequencer #(
        .ADDR_BITS      (c_AW),
        .OP_BITS        (c_OW),
        .TIMEOUT_CYCLES (c_TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_a     (instr_a),
        .instr_b     (instr_b),
        .instr_dst   (instr_dst),
        .mem_addr_a  (mem_addr_a),
        .mem_addr_b  (mem_addr_b),
        .mem_addr_i  (mem_addr_i),
        .mem_write   (mem_write),
        .cu_start    (cu_start),
        .cu_op       (cu_op),
        .cu_done     (cu_done),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_clear   (err_clear),
        .op_count    (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] v0;
        logic [31:0] v1;
        logic [31:0] v2;
    } ev_t;

    ev_t start_q[$];
    ev_t write_q[$];
    ev_t retire_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    logic [15:0]     m_count = 16'd0;
    logic            m_err   = 1'b0;
    logic [c_AW-1:0] m_addr_a = '0;
    logic [c_AW-1:0] m_addr_b = '0;
    logic [c_AW-1:0] m_addr_i = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event with nothing expected (cycle %0d)", name, cyc);
    endtask

    // Monitor: compares each DUT event against the head of its queue
    logic [15:0] mon_prev = 16'd0;
    always @(negedge clk) begin
        if (rst) begin
            mon_prev = 16'd0;
        end else begin
            if (cu_start) begin
                if (start_q.size() == 0) unexpected("cu_start");
                else begin
                    ev_t e;
                    e = start_q.pop_front();
                    check("start_cycle", cyc, e.cyc);
                    check("cu_op", 32'(cu_op), e.v0);
                    check("mem_addr_a", 32'(mem_addr_a), e.v1);
                    check("mem_addr_b", 32'(mem_addr_b), e.v2);
                end
            end
            if (mem_write) begin
                if (write_q.size() == 0) unexpected("mem_write");
                else begin
                    ev_t e;
                    e = write_q.pop_front();
                    check("write_cycle", cyc, e.cyc);
                    check("mem_addr_i", 32'(mem_addr_i), e.v0);
                end
            end
            if (op_count != mon_prev) begin
                if (retire_q.size() == 0) unexpected("op_count");
                else begin
                    ev_t e;
                    e = retire_q.pop_front();
                    check("retire_cycle", cyc, e.cyc);
                    check("op_count", 32'(op_count), e.v0);
                    check("err_timeout", 32'(err_timeout), e.v1);
                end
                mon_prev = op_count;
            end
        end
    end

    task automatic scramble();
        instr_op  = c_OW'($urandom);
        instr_a   = c_AW'($urandom);
        instr_b   = c_AW'($urandom);
        instr_dst = c_AW'($urandom);
    endtask

    // Issue one instruction. k: cycles after entering WAIT before cu_done
    // (k >= c_TO means cu_done never comes). clr_at_to pulses err_clear on
    // the final WAIT cycle of a timeout. Returns at posedge+1 with the DUT idle.
    task automatic do_op(input logic [c_OW-1:0] op, input logic [c_AW-1:0] a,
                         input logic [c_AW-1:0] b, input logic [c_AW-1:0] dst,
                         input int k, input bit clr_at_to);
        int w;
        int t;
        int tgt;
        int ret_cyc;
        ev_t e;
        instr_valid = 1'b1;
        instr_op    = op;
        instr_a     = a;
        instr_b     = b;
        instr_dst   = dst;
        w = 0;
        @(negedge clk);
        while (!instr_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (!instr_ready) begin
            unexpected("accept_wait_expired");
            instr_valid = 1'b0;
            return;
        end
        t = cyc;
        ret_cyc = t + 1;
        if (op == '0) begin
            m_count++;
            e = '{t + 1, 32'(m_count), 32'(m_err), 32'd0};
            retire_q.push_back(e);
        end else begin
            m_addr_a = a;
            m_addr_b = b;
            e = '{t + 2, 32'(op), 32'(a), 32'(b)};
            start_q.push_back(e);
            m_count++;
            if (k < c_TO) begin
                m_addr_i = dst;
                e = '{t + 4 + k, 32'(dst), 32'd0, 32'd0};
                write_q.push_back(e);
                ret_cyc = t + 5 + k;
            end else begin
                m_err = 1'b1;
                ret_cyc = t + 3 + c_TO;
            end
            e = '{ret_cyc, 32'(m_count), 32'(m_err), 32'd0};
            retire_q.push_back(e);
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        scramble();
        if (op != '0) begin
            tgt = (k < c_TO) ? t + 3 + k : t + 2 + c_TO;
            while (cyc < tgt) begin
                @(posedge clk);
                #1;
                scramble();
            end
            if (k < c_TO) cu_done = 1'b1;
            else if (clr_at_to) err_clear = 1'b1;
            @(posedge clk);
            #1;
            cu_done   = 1'b0;
            err_clear = 1'b0;
            while (cyc < ret_cyc) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic clear_err();
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        err_clear = 1'b0;
        m_err = 1'b0;
        @(negedge clk);
        check("err_after_clear", 32'(err_timeout), 32'(m_err));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst = 1'b1;
        instr_valid = 1'b0;
        cu_done = 1'b0;
        err_clear = 1'b0;
        scramble();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {instr_ready, mem_write, cu_start, busy, err_timeout, 11'd0, op_count},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 16'd0});
        check("reset_addrs", {8'd0, mem_addr_a, mem_addr_b, mem_addr_i, cu_op}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single op, done on the first WAIT cycle
        do_op(4'd3, 6'd5, 6'd9, 6'd12, 0, 1'b0);
        check("ready_after_op", 32'(instr_ready), 32'd1);
        check("count_after_op", 32'(op_count), 32'd1);

        // Back-to-back NOPs
        repeat (3) do_op(4'd0, 6'($urandom), 6'($urandom), 6'($urandom), 0, 1'b0);
        check("count_after_nops", 32'(op_count), 32'd4);

        // Timeout, then clear
        do_op(4'd7, 6'd1, 6'd2, 6'd3, c_TO + 5, 1'b0);
        @(negedge clk);
        check("err_set", 32'(err_timeout), 32'd1);
        check("addr_i_no_write", 32'(mem_addr_i), 32'(m_addr_i));
        @(posedge clk);
        #1;
        clear_err();

        // Done on the exact timeout cycle wins
        do_op(4'd9, 6'd20, 6'd21, 6'd20, c_TO - 1, 1'b0);
        @(negedge clk);
        check("err_done_wins", 32'(err_timeout), 32'd0);

        // Spurious done and toggling inputs while idle
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            scramble();
            cu_done = 1'($urandom);
        end
        @(posedge clk);
        #1;
        cu_done = 1'b0;
        @(negedge clk);
        check("idle_addrs", {14'd0, mem_addr_a, mem_addr_b, mem_addr_i},
              {14'd0, m_addr_a, m_addr_b, m_addr_i});
        check("idle_status", {29'd0, instr_ready, busy, mem_write}, 32'd4);

        // Asynchronous reset during WAIT
        @(posedge clk);
        #1;
        instr_valid = 1'b1;
        instr_op = 4'd5; instr_a = 6'd11; instr_b = 6'd22; instr_dst = 6'd33;
        @(negedge clk);
        t = cyc;
        start_q.push_back('{t + 2, 32'd5, 32'd11, 32'd22});
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        while (cyc < t + 4) begin
            @(posedge clk);
            #1;
        end
        check("busy_in_wait", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs",
              {instr_ready, mem_write, cu_start, busy, err_timeout, 11'd0, op_count},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 16'd0});
        check("async_reset_addrs", {8'd0, mem_addr_a, mem_addr_b, mem_addr_i, cu_op}, 32'd0);
        m_count = 16'd0; m_err = 1'b0;
        m_addr_a = '0; m_addr_b = '0; m_addr_i = '0;
        start_q.delete(); write_q.delete(); retire_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cu_done = 1'b1;
        @(posedge clk);
        #1;
        cu_done = 1'b0;
        do_op(4'd2, 6'd40, 6'd41, 6'd42, 2, 1'b0);
        check("count_after_reset_op", 32'(op_count), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            logic [c_OW-1:0] op;
            int k;
            op = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            k  = $urandom_range(0, c_TO + 2);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
                cu_done = 1'b1;
                @(posedge clk);
                #1;
                cu_done = 1'b0;
            end
            if (m_err && $urandom_range(0, 1) == 0) clear_err();
            do_op(op, 6'($urandom), 6'($urandom), 6'($urandom), k, 1'($urandom));
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("final_count", 32'(op_count), 32'(m_count));
        check("queues_drained", start_q.size() + write_q.size() + retire_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
